mips_debug_sequencer: RTL

- Sequences the MIPS pipeline from the UART debug link.
- Receives command bytes and loads program bytes into instruction memory.
- Gates the pipeline clock-enable for free-run or single-step, and reports PC (and optionally the cycle count) back over TX.
- Sits between the UART rx/tx pair and the IF stage/pipeline enable inside the top-level wrapper.

---
 rtl/mips_debug_pkg.sv | 32 +++
 rtl/mips_debug_sequencer_serializer.sv | 79 +++++++
 rtl/mips_debug_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS debug sequencer: FSM encodings, UART
// command bytes and the HALT instruction word.
package mips_debug_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_LOAD   = 4'b0001,
        ST_RUN    = 4'b0010,
        ST_STEP   = 4'b0011,
        ST_SEND   = 4'b0100,
        ST_LEN_H  = 4'b0101,
        ST_LEN_L  = 4'b0110,
        ST_HALTED = 4'b0111
    } state_t;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_WAIT = 2'd1,
        SER_GAP  = 2'd2
    } ser_state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_PC    = 8'h50;
    localparam logic [7:0] CMD_RESET = 8'h45;
    localparam logic [7:0] CMD_BREAK = 8'h42;
    localparam logic [7:0] CMD_COUNT = 8'h43;

    localparam logic [31:0] HALT_INSTR = 32'hFFFFFFFF;

endpackage

// File: rtl/mips_debug_sequencer_serializer.sv
// debug_tx_serializer: shifts out up to 8 bytes MSB first over the UART
// start/busy handshake and pulses done after the last byte is started.
module debug_tx_serializer
    import mips_debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] data,
    input  logic [3:0]  len,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        done
);

    ser_state_t  st, st_d;
    logic [63:0] sh, sh_d;
    logic [3:0]  rem, rem_d;
    logic        start_d, done_d;
    logic [7:0]  txd_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= SER_IDLE;
            sh       <= '0;
            rem      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
        end else begin
            st       <= st_d;
            sh       <= sh_d;
            rem      <= rem_d;
            tx_start <= start_d;
            tx_data  <= txd_d;
            done     <= done_d;
        end
    end

    // Handshake: wait for idle UART, pulse start, then give busy one cycle to rise
    always_comb begin
        st_d    = st;
        sh_d    = sh;
        rem_d   = rem;
        start_d = 1'b0;
        txd_d   = tx_data;
        done_d  = 1'b0;
        case (st)
            SER_IDLE: begin
                if (load) begin
                    sh_d  = data;
                    rem_d = len;
                    st_d  = (len == 4'd0) ? SER_GAP : SER_WAIT;
                end
            end
            SER_WAIT: begin
                if (!tx_busy) begin
                    start_d = 1'b1;
                    txd_d   = sh[63:56];
                    sh_d    = {sh[55:0], 8'h00};
                    rem_d   = rem - 1'b1;
                    st_d    = SER_GAP;
                end
            end
            SER_GAP: begin
                if (rem == 4'd0) begin
                    done_d = 1'b1;
                    st_d   = SER_IDLE;
                end else begin
                    st_d = SER_WAIT;
                end
            end
            default: st_d = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/mips_debug_sequencer.sv
// mips_debug_sequencer: UART-driven program loader and run/step controller
// for the MIPS pipeline. Define MIPS_DEBUG_CYCLE_COUNT_EN to add a 32-bit
// run-cycle counter readable with 'C' and appended to the HALTED report.
module mips_debug_sequencer
    import mips_debug_pkg::*;
#(
    parameter int IMEM_ADDR_W = 10,
    parameter int PC_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_tx_busy,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [7:0]             o_imem_wdata,
    output logic                   o_mips_en,
    output logic                   o_mips_rst,
    input  logic                   i_halt,
    input  logic [PC_W-1:0]        i_pc,
    output logic [3:0]             o_state
);

    state_t                 state, state_d;
    logic                   en_d, mrst_d, we_d;
    logic [IMEM_ADDR_W-1:0] addr_d, ptr, ptr_d;
    logic [7:0]             wdata_d, lenh, lenh_d;
    logic [17:0]            cnt, cnt_d;
    logic [31:0]            pc32;
    logic                   ser_load, ser_done;
    logic [3:0]             ser_len;
    logic [63:0]            ser_data;

    assign pc32    = 32'(i_pc);
    assign o_state = state;

`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
    logic [31:0] cyc, cyc_now;
    logic        cyc_clr;

    // Value including the cycle in flight, so a halt report counts its own cycle
    assign cyc_now = cyc + {31'd0, o_mips_en};

    // Run-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cyc <= '0;
        else if (cyc_clr)  cyc <= '0;
        else if (o_mips_en) cyc <= cyc + 32'd1;
    end
`endif

    // FSM state and registered pipeline/imem controls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            o_mips_en    <= 1'b0;
            o_mips_rst   <= 1'b1;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            ptr          <= '0;
            cnt          <= '0;
            lenh         <= '0;
        end else begin
            state        <= state_d;
            o_mips_en    <= en_d;
            o_mips_rst   <= mrst_d;
            o_imem_we    <= we_d;
            o_imem_addr  <= addr_d;
            o_imem_wdata <= wdata_d;
            ptr          <= ptr_d;
            cnt          <= cnt_d;
            lenh         <= lenh_d;
        end
    end

    // Next state, next control values, and serializer load requests
    always_comb begin
        state_d  = state;
        en_d     = 1'b0;
        mrst_d   = 1'b0;
        we_d     = 1'b0;
        addr_d   = o_imem_addr;
        wdata_d  = o_imem_wdata;
        ptr_d    = ptr;
        cnt_d    = cnt;
        lenh_d   = lenh;
        ser_load = 1'b0;
        ser_len  = 4'd4;
        ser_data = {pc32, 32'h0};
`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
        cyc_clr  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_d = ST_LEN_H;
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            en_d    = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d = ST_STEP;
                            en_d    = 1'b1;
                        end
                        CMD_PC: begin
                            state_d  = ST_SEND;
                            ser_load = 1'b1;
                        end
                        CMD_RESET: begin
                            mrst_d = 1'b1;
`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
                            cyc_clr = 1'b1;
`endif
                        end
`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
                        CMD_COUNT: begin
                            state_d  = ST_SEND;
                            ser_load = 1'b1;
                            ser_data = {cyc, 32'h0};
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_LEN_H: begin
                if (i_rx_valid) begin
                    lenh_d  = i_rx_data;
                    state_d = ST_LEN_L;
                end
            end
            ST_LEN_L: begin
                if (i_rx_valid) begin
                    if ({lenh, i_rx_data} == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                        cnt_d   = {lenh, i_rx_data, 2'b00};
                        ptr_d   = '0;
                        mrst_d  = 1'b1;
`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
                        cyc_clr = 1'b1;
`endif
                    end
                end
            end
            ST_LOAD: begin
                // Pipeline held in reset through the final write cycle too
                mrst_d = 1'b1;
                if (i_rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = ptr;
                    wdata_d = i_rx_data;
                    ptr_d   = ptr + 1'b1;
                    cnt_d   = cnt - 1'b1;
                    if (cnt == 18'd1) state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Halt takes priority over a coincident break
                if (i_halt) begin
                    state_d  = ST_HALTED;
                    ser_load = 1'b1;
`ifdef MIPS_DEBUG_CYCLE_COUNT_EN
                    ser_len  = 4'd8;
                    ser_data = {pc32, cyc_now};
`endif
                end else if (i_rx_valid && i_rx_data == CMD_BREAK) begin
                    state_d = ST_IDLE;
                end else begin
                    en_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d  = ST_SEND;
                ser_load = 1'b1;
            end
            ST_SEND, ST_HALTED: begin
                if (ser_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    debug_tx_serializer u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .data     (ser_data),
        .len      (ser_len),
        .tx_busy  (i_tx_busy),
        .tx_start (o_tx_start),
        .tx_data  (o_tx_data),
        .done     (ser_done)
    );

endmodule
